// File: rtl/serial_signed_adder.sv
// ---------------------------------------------------------------------------
// serial_signed_adder
//
// Bit-serial two's-complement adder. A start request latches both operands,
// after which one full-adder step is performed per clock, LSB first. When the
// MSB step completes, the result, the carry out of the MSB and the signed
// overflow flags are published together, and done pulses for one cycle.
//
// Parameters
//   WIDTH  operand / result width in bits (minimum 2)
//
// Ports
//   clk    single clock, rising-edge active
//   rst    synchronous active-high reset
//   start  operation request, honoured only in IDLE
//   A, B   signed addends, sampled on the edge that accepts start
//   sum    A+B modulo 2^WIDTH, held until the next completed operation
//   Cout   carry out of the MSB
//   OvP    positive overflow (two non-negatives produced a negative)
//   OvN    negative overflow (two negatives produced a non-negative)
//   busy   high whenever the FSM is not IDLE
//   done   one-cycle result-valid pulse
// ---------------------------------------------------------------------------
module serial_signed_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] sum,
  output logic             Cout,
  output logic             OvP,
  output logic             OvN,
  output logic             busy,
  output logic             done
);

  // Bit counter just wide enough to index every operand bit.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // Working result assembled bit by bit; kept separate from sum so the
  // visible output only changes when the whole word is complete.
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovp_q, ovp_d;
  logic             ovn_q, ovn_d;

  // One full-adder step on the bit selected by the counter.
  logic a_bit, b_bit, s_bit, c_bit;

  always_comb begin
    a_bit = a_q[cnt_q];
    b_bit = b_q[cnt_q];
    s_bit = a_bit ^ b_bit ^ carry_q;
    c_bit = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovp_d   = ovp_q;
    ovn_d   = ovn_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          res_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        res_d[cnt_q] = s_bit;
        carry_d      = c_bit;
        cnt_d        = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // MSB step: publish the completed word and flags together.
          cnt_d   = '0;
          sum_d   = res_d;
          cout_d  = c_bit;
          ovp_d   = ~a_q[WIDTH-1] & ~b_q[WIDTH-1] &  s_bit;
          ovn_d   =  a_q[WIDTH-1] &  b_q[WIDTH-1] & ~s_bit;
          state_d = DONE;
        end
      end

      DONE: begin
        // start is ignored here; the first IDLE cycle may accept a new one.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset wins over everything, including start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovp_q   <= 1'b0;
      ovn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovp_q   <= ovp_d;
      ovn_q   <= ovn_d;
    end
  end

  assign sum  = sum_q;
  assign Cout = cout_q;
  assign OvP  = ovp_q;
  assign OvN  = ovn_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: doc/serial_signed_adder.md
SERIAL_SIGNED_ADDER -- requirements
Module: serial_signed_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled on a rising edge.
REQ-005 The block SHALL have port A, input, WIDTH bits: signed two's-complement addend.
REQ-006 The block SHALL have port B, input, WIDTH bits: signed two's-complement addend.
REQ-007 The block SHALL have port sum, output, WIDTH bits: signed result A+B, modulo 2^WIDTH.
REQ-008 The block SHALL have port Cout, output, 1 bit: carry out of the MSB.
REQ-009 The block SHALL have port OvP, output, 1 bit: positive overflow flag.
REQ-010 The block SHALL have port OvN, output, 1 bit: negative overflow flag.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle result-valid pulse.

Function
REQ-013 The FSM SHALL have three states (IDLE, RUN, DONE) plus a bit counter of ceil(log2(WIDTH)) bits.
REQ-014 In IDLE with start=1 at an edge, the block SHALL latch A and B into internal shift registers, clear the carry register and the counter, and enter RUN.
REQ-015 In IDLE with start=0, the block SHALL remain in IDLE with all outputs held.
REQ-016 In RUN, each edge SHALL perform one full-adder step on bit[counter] of the latched operands and the carry register: store the sum bit in result bit[counter], update the carry, and increment the counter; LSB is processed first.
REQ-017 The edge in RUN with counter = WIDTH-1 SHALL complete the MSB step, load Cout from the final carry, compute the overflow flags and enter DONE.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle, after which the block SHALL return to IDLE.
REQ-019 The latency from the start-sampling edge to the cycle with done=1 SHALL be WIDTH+1 edges (9 edges for WIDTH=8).
REQ-020 OvP SHALL equal ~A[MSB] & ~B[MSB] & sum[MSB], and OvN SHALL equal A[MSB] & B[MSB] & ~sum[MSB], using the latched operands.
REQ-021 start SHALL be ignored in RUN and DONE; no queuing occurs and the operation in flight is unaffected.
REQ-022 Changes on A and B after the start-sampling edge SHALL NOT affect the result.
REQ-023 sum, Cout, OvP and OvN SHALL change only at the edge entering DONE, and SHALL hold their values until the next completed operation.
REQ-024 A start sampled in the first IDLE cycle after DONE SHALL be accepted, giving a back-to-back throughput of one result per WIDTH+2 cycles.

Reset
REQ-025 When rst=1 at an edge, the block SHALL enter IDLE and clear the counter, the carry register, the operand registers, sum, Cout, OvP, OvN, busy and done to 0.
REQ-026 rst SHALL take priority over start and over any in-flight operation; a reset mid-RUN SHALL abort the operation and no done pulse follows.
REQ-027 start asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-028 The bench SHALL cover: A=100 (0x64), B=27 (0x1B), start for 1 cycle -> after 9 edges done=1, sum=0x7F, Cout=0, OvP=0, OvN=0.
REQ-029 The bench SHALL cover: A=100, B=28 -> sum=0x80, Cout=0, OvP=1, OvN=0.
REQ-030 The bench SHALL cover: A=-128 (0x80), B=-1 (0xFF) -> sum=0x7F, Cout=1, OvP=0, OvN=1.
REQ-031 The bench SHALL cover: A=-1, B=1 -> sum=0x00, Cout=1, OvP=0, OvN=0; then A and B are changed to 0x55 during RUN -> result is unaffected.
REQ-032 The bench SHALL cover: start pulsed again at edge 4 of an operation with A=3, B=4 -> exactly one done pulse, sum=0x07; then start in the first IDLE cycle after DONE is accepted.
REQ-033 The bench SHALL cover: rst=1 at edge 5 of an operation -> next cycle busy=0, done=0, sum=0, all flags 0, and no done pulse follows.
